// File: rtl/alua.sv
// alua: registered logic slice of the datapath ALU.
// Selects AND / OR / XOR / NOT-A over two WIDTH-bit operands and registers the
// result every cycle. cout mirrors the arithmetic slice's port set and is held low.
module alua #(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [1:0]       S,
   output logic [WIDTH-1:0] IS,
   output logic             cout
);

   typedef enum logic [1:0] {
      OP_AND  = 2'd0,
      OP_OR   = 2'd1,
      OP_XOR  = 2'd2,
      OP_NOTA = 2'd3
   } op_e;

   op_e              op;
   logic [WIDTH-1:0] result_next;

   assign op = op_e'(S);

   // Next result from the current operands and opcode; B is unused for NOT A.
   always_comb begin
      // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
      result_next = '0;
      case (op)
         OP_AND:  result_next = A & B;
         OP_OR:   result_next = A | B;
         OP_XOR:  result_next = A ^ B;
         OP_NOTA: result_next = ~A;
         default: result_next = '0;
      endcase
   end

   // Output register: synchronous reset wins over the computed result.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         IS   <= '0;
         cout <= 1'b0;
      end else begin
         IS   <= result_next;
         cout <= 1'b0;
      end
   end

endmodule

// File: tb/tb_alua.sv
// tb_alua: directed self-checking bench for alua.
// A bit-level arithmetic model predicts the registered outputs every cycle;
// directed steps also carry hand-computed literal expectations.
module tb_alua;

   localparam int W = 8;

   logic         clk;
   logic         rst_n;
   logic [W-1:0] A;
   logic [W-1:0] B;
   logic [1:0]   S;
   logic [W-1:0] IS;
   logic         cout;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_is;
   logic         model_valid;

   alua #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .A    (A),
      .B    (B),
      .S    (S),
      .IS   (IS),
      .cout (cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Per-bit arithmetic truth tables on 0/1 integers.
   function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic [1:0] s);
      logic [W-1:0] r;
      int x, y, v;
      r = '0;
      for (int i = 0; i < W; i++) begin
         x = int'(a[i]);
         y = int'(b[i]);
         case (int'(s))
            0:       v = x * y;
            1:       v = x + y - x * y;
            2:       v = x + y - 2 * x * y;
            default: v = 1 - x;
         endcase
         r[i] = (v != 0);
      end
      return r;
   endfunction

   // Model: what each edge must load, from the inputs present at that edge.
   initial model_valid = 1'b0;
   always @(posedge clk) begin
      exp_is      <= rst_n ? model(A, B, S) : '0;
      model_valid <= 1'b1;
   end

   // Continuous comparison, half a cycle away from the active edge.
   always @(negedge clk) begin
      if (model_valid) begin
         check("stream_is", 32'(IS), 32'(exp_is));
         check("stream_cout", 32'(cout), 32'd0);
      end
   end

   // One cycle: drive inputs, let an edge sample them, compare with a literal.
   task automatic step(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                       input logic rn, input logic [W-1:0] lit, input string name);
      @(negedge clk);
      #1;
      A     = a;
      B     = b;
      S     = s;
      rst_n = rn;
      @(posedge clk);
      #1;
      check(name, 32'(IS), 32'(lit));
      check({name, "_cout"}, 32'(cout), 32'd0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      A     = 8'hFF;
      B     = 8'hFF;
      S     = 2'd1;

      // Reset held for two edges, then released.
      step(8'hFF, 8'hFF, 2'd1, 1'b0, 8'h00, "rst_edge0");
      step(8'hFF, 8'hFF, 2'd1, 1'b0, 8'h00, "rst_edge1");
      step(8'hFF, 8'hFF, 2'd1, 1'b1, 8'hFF, "rst_release");

      // AND truth table on bit 0.
      step(8'h00, 8'h00, 2'd0, 1'b1, 8'h00, "and_00");
      step(8'h00, 8'h01, 2'd0, 1'b1, 8'h00, "and_01");
      step(8'h01, 8'h00, 2'd0, 1'b1, 8'h00, "and_10");
      step(8'h01, 8'h01, 2'd0, 1'b1, 8'h01, "and_11");

      // OR truth table.
      step(8'h00, 8'h00, 2'd1, 1'b1, 8'h00, "or_00");
      step(8'h00, 8'h01, 2'd1, 1'b1, 8'h01, "or_01");
      step(8'h01, 8'h00, 2'd1, 1'b1, 8'h01, "or_10");
      step(8'h01, 8'h01, 2'd1, 1'b1, 8'h01, "or_11");

      // XOR truth table.
      step(8'h00, 8'h00, 2'd2, 1'b1, 8'h00, "xor_00");
      step(8'h00, 8'h01, 2'd2, 1'b1, 8'h01, "xor_01");
      step(8'h01, 8'h00, 2'd2, 1'b1, 8'h01, "xor_10");
      step(8'h01, 8'h01, 2'd2, 1'b1, 8'h00, "xor_11");

      // NOT A, B ignored.
      step(8'h00, 8'h00, 2'd3, 1'b1, 8'hFF, "nota_0");
      step(8'h01, 8'h00, 2'd3, 1'b1, 8'hFE, "nota_1");
      step(8'h01, 8'hAA, 2'd3, 1'b1, 8'hFE, "nota_b_ignored");

      // Full width, opcode stepped every cycle.
      step(8'hF0, 8'h3C, 2'd0, 1'b1, 8'h30, "full_and");
      step(8'hF0, 8'h3C, 2'd1, 1'b1, 8'hFC, "full_or");
      step(8'hF0, 8'h3C, 2'd2, 1'b1, 8'hCC, "full_xor");
      step(8'hF0, 8'h3C, 2'd3, 1'b1, 8'h0F, "full_nota");

      // Same sequence with a one-cycle reset at the XOR step.
      step(8'hF0, 8'h3C, 2'd0, 1'b1, 8'h30, "mid_and");
      step(8'hF0, 8'h3C, 2'd1, 1'b1, 8'hFC, "mid_or");
      step(8'hF0, 8'h3C, 2'd2, 1'b0, 8'h00, "mid_rst");
      step(8'hF0, 8'h3C, 2'd3, 1'b1, 8'h0F, "mid_resume");

      // Model sanity against hand-computed values.
      check("model_and", 32'(model(8'hF0, 8'h3C, 2'd0)), 32'h30);
      check("model_xor", 32'(model(8'hA5, 8'hFF, 2'd2)), 32'h5A);
      check("model_nota", 32'(model(8'h5A, 8'h00, 2'd3)), 32'hA5);

      @(negedge clk);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
